// File: rtl/hcm_access_arbiter.sv
// hcm_access_arbiter: sequences buffered writes, reads and event clears into one HCMPP and re-times read data.
// Optional grant/stall counters are enabled by defining HCM_ARB_STATS_EN.
module hcm_access_arbiter #(
  parameter int ROWINDEXBITS   = 16,
  parameter int NCOLS          = 16,
  parameter int WFIFO_DEPTH    = 4,
  parameter int HCM_RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ROWINDEXBITS-1:0] wr_row,
  input  logic                    wr_is_new,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ROWINDEXBITS-1:0] rd_row,
  input  logic                    evt_clear,
  output logic                    clear_done,
  output logic                    hcm_write_row,
  output logic [ROWINDEXBITS-1:0] hcm_row_to_write,
  output logic                    hcm_ssid_is_new,
  output logic                    hcm_read_row,
  output logic [ROWINDEXBITS-1:0] hcm_row_to_read,
  output logic                    hcm_reset,
  input  logic                    hcm_busy,
  input  logic [ROWINDEXBITS-1:0] hcm_row_passed,
  input  logic [NCOLS-1:0]        hcm_row_read_output,
  output logic                    rd_data_valid,
  output logic [NCOLS-1:0]        rd_data,
  output logic [ROWINDEXBITS-1:0] rd_data_row
`ifdef HCM_ARB_STATS_EN
  ,
  output logic [31:0]             stat_wr_grants,
  output logic [31:0]             stat_rd_grants,
  output logic [31:0]             stat_busy_stalls
`endif
);
  localparam int AW = $clog2(WFIFO_DEPTH);
  typedef enum logic [1:0] {ARB, CLEAR, WAIT_CLEAR} state_t;
  state_t state, state_nx;
  logic [ROWINDEXBITS-1:0] row_mem [WFIFO_DEPTH];
  logic [WFIFO_DEPTH-1:0] new_mem, vld;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [HCM_RD_LATENCY-1:0] pipe;
  logic rr, clr_pend, clr_req, empty, full, push, hazard, rd_ok, wr_pend;
  logic in_flight, grant_w, grant_r, done_nx;
  assign empty     = count == '0;
  assign full      = count == (AW+1)'(WFIFO_DEPTH);
  assign clr_req   = clr_pend | evt_clear;
  assign in_flight = hcm_read_row | (|pipe);
  assign wr_ready  = state == ARB && !full && !clr_req;
  assign push      = wr_valid && wr_ready;
  assign wr_pend   = !empty;
  assign rd_ok     = rd_valid && !hazard && !clr_req;
  assign grant_w   = state == ARB && !hcm_busy && wr_pend && (!rd_ok || !rr);
  assign grant_r   = state == ARB && !hcm_busy && rd_ok && (!wr_pend || rr);
  assign rd_ready  = grant_r;
  assign rd_data_valid = pipe[HCM_RD_LATENCY-1];
  assign rd_data     = rd_data_valid ? hcm_row_read_output : '0;
  assign rd_data_row = rd_data_valid ? hcm_row_passed : '0;
  assign hcm_reset   = state == CLEAR;
  // A read may not overtake a buffered write to the same row.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WFIFO_DEPTH; i++) hazard = hazard | (vld[i] && row_mem[i] == rd_row);
  end
  always_comb begin
    state_nx = (state == ARB)   ? ((clr_req && empty && !in_flight) ? CLEAR : ARB) :
               (state == CLEAR) ? WAIT_CLEAR :
               (hcm_busy ? WAIT_CLEAR : ARB);
    done_nx  = state == WAIT_CLEAR && !hcm_busy;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      row_mem[wptr] <= wr_row;
      new_mem[wptr] <= wr_is_new;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ARB;
      clear_done       <= 1'b0;
      clr_pend         <= 1'b0;
      rr               <= 1'b0;
      wptr             <= '0;
      rptr             <= '0;
      count            <= '0;
      vld              <= '0;
      pipe             <= '0;
      hcm_write_row    <= 1'b0;
      hcm_row_to_write <= '0;
      hcm_ssid_is_new  <= 1'b0;
      hcm_read_row     <= 1'b0;
      hcm_row_to_read  <= '0;
    end else begin
      state            <= state_nx;
      clear_done       <= done_nx;
      clr_pend         <= done_nx ? 1'b0 : clr_req;
      rr               <= (grant_w | grant_r) ? ~rr : rr;
      wptr             <= push ? wptr + 1'b1 : wptr;
      rptr             <= grant_w ? rptr + 1'b1 : rptr;
      count            <= count + (AW+1)'(push) - (AW+1)'(grant_w);
      vld              <= (vld | (WFIFO_DEPTH'(push) << wptr)) & ~(WFIFO_DEPTH'(grant_w) << rptr);
      pipe             <= (pipe << 1) | HCM_RD_LATENCY'(hcm_read_row);
      hcm_write_row    <= grant_w;
      hcm_row_to_write <= grant_w ? row_mem[rptr] : '0;
      hcm_ssid_is_new  <= grant_w && new_mem[rptr];
      hcm_read_row     <= grant_r;
      hcm_row_to_read  <= grant_r ? rd_row : '0;
    end
  end
`ifdef HCM_ARB_STATS_EN
  logic stall;
  assign stall = state == ARB && hcm_busy && (wr_pend || rd_ok);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_wr_grants   <= '0;
      stat_rd_grants   <= '0;
      stat_busy_stalls <= '0;
    end else begin
      stat_wr_grants   <= (grant_w && !(&stat_wr_grants)) ? stat_wr_grants + 32'd1 : stat_wr_grants;
      stat_rd_grants   <= (grant_r && !(&stat_rd_grants)) ? stat_rd_grants + 32'd1 : stat_rd_grants;
      stat_busy_stalls <= (stall && !(&stat_busy_stalls)) ? stat_busy_stalls + 32'd1 : stat_busy_stalls;
    end
  end
`endif
endmodule

// File: doc/hcm_access_arbiter.md
Name: hcm_access_arbiter

Overview:
- Sequences all traffic into one HCMPP instance: a buffered SSID write stream (row index plus is-new flag), a readout request stream, and an event-boundary clear.
- Presents a single command per cycle to the HCM and honours the HCM busy flag.
- Re-times read data back to the requester with its row tag.
- Sits between the SSID-matching front end / readout logic and the HCM.

Parameters:
- ROWINDEXBITS, 16, HCM row index width.
- NCOLS, 16, HCM row width (read data width).
- WFIFO_DEPTH, 4, write buffer entries; power of 2, minimum 2.
- HCM_RD_LATENCY, 2, cycles from hcm_read_row issue to valid HCM read output; minimum 1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write FIFO not full.
- wr_row  in  ROWINDEXBITS  row to write.
- wr_is_new  in  1  SSID is new for this event.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_row  in  ROWINDEXBITS  row to read.
- evt_clear  in  1  one-cycle pulse: clear the HCM for the next event.
- clear_done  out  1  one-cycle pulse when the clear completes.
- hcm_write_row  out  1  HCM write strobe.
- hcm_row_to_write  out  ROWINDEXBITS  HCM write row.
- hcm_ssid_is_new  out  1  HCM is-new flag.
- hcm_read_row  out  1  HCM read strobe.
- hcm_row_to_read  out  ROWINDEXBITS  HCM read row.
- hcm_reset  out  1  HCM clear pulse, active-high.
- hcm_busy  in  1  HCM cannot accept a command.
- hcm_row_passed  in  ROWINDEXBITS  row tag from the HCM.
- hcm_row_read_output  in  NCOLS  read data from the HCM.
- rd_data_valid  out  1  read data valid.
- rd_data  out  NCOLS  read data.
- rd_data_row  out  ROWINDEXBITS  row of rd_data.

Behaviour:
- Reset: all outputs 0 except wr_ready, which is 1. FIFO is empty, state is ARB, the round-robin pointer favours write, and the read pipeline is cleared. A reset mid-operation drops buffered writes and in-flight reads; no rd_data_valid is produced for them.
- Write accept: a write is pushed when wr_valid and wr_ready are both 1. wr_ready is 0 when the FIFO is full, or when the state is CLEAR or WAIT_CLEAR.
- States:
  - ARB: pending request sources are a non-empty FIFO and rd_valid. At most one HCM command is issued per cycle, and only when hcm_busy is 0. If both sources are pending, grant round-robin; the pointer flips after every grant.
  - CLEAR: hcm_reset is 1 for exactly one cycle, then go to WAIT_CLEAR.
  - WAIT_CLEAR: wait for hcm_busy to be 0, then pulse clear_done for one cycle and return to ARB.
- Issue timing: commands are registered. On the cycle after a grant, exactly one of hcm_write_row or hcm_read_row is 1, with its row and flag outputs valid.
- Read hazard: a read whose rd_row matches any valid FIFO entry is not granted, and rd_ready stays 0, until that entry has drained. Writes then proceed alone.
- Read pop: rd_ready is 1 only in the grant cycle for the read.
- evt_clear:
  - Latched as pending.
  - Leave ARB for CLEAR only when the FIFO is empty and no read is in flight.
  - New writes are blocked (wr_ready = 0) from the latch cycle onward.
  - Reads are not granted while a clear is pending.
  - A second evt_clear while one is pending is absorbed.
- Read return: a valid-shift pipeline of depth HCM_RD_LATENCY. rd_data_valid is 1 exactly HCM_RD_LATENCY cycles after hcm_read_row, with rd_data = hcm_row_read_output and rd_data_row = hcm_row_passed sampled in that cycle. Back-to-back reads give back-to-back valids.
- hcm_busy is 1 while a request is pending: no issue occurs, FIFO contents are held, and the round-robin pointer does not move.
- Simultaneous FIFO push and pop when full: the push is refused, because wr_ready was already 0.
- Row arithmetic: rows pass through unmodified, so row 2^ROWINDEXBITS-1 (e.g. 65535) is legal.

Optional Feature:
- Macro HCM_ARB_STATS_EN.
- Defined: adds three 32-bit saturating counters — stat_wr_grants, stat_rd_grants and stat_busy_stalls (cycles in which a request was pending and hcm_busy was 1). They are exposed as output ports, cleared by reset, and not cleared by evt_clear.
- Undefined: the ports and the logic are absent.

Test Plan:
- Push writes rows 3, 1, 65534 with is_new 1, 0, 1; hcm_busy=0 → hcm_write_row on 3 consecutive cycles, rows and flags in the same order; wr_ready stays 1.
- Hold hcm_busy=1 and push 5 writes with WFIFO_DEPTH=4 → wr_ready=0 after the 4th push; release busy → 4 writes issue in order, and the 5th is accepted afterwards.
- Continuous writes and reads (rows 7 and 9) pending together → grants alternate W, R, W, R; rd_data_valid with rd_data_row=9 appears 2 cycles after each hcm_read_row.
- FIFO holds row 4 with busy=1, rd_row=4 presented → rd_ready=0 until the write to row 4 issues; the read issues on the next grant.
- evt_clear while 2 writes are buffered → both writes issue, then hcm_reset=1 for one cycle; with busy held 5 cycles, clear_done pulses once after busy falls; wr_ready=0 throughout.
- Assert reset (0) while the FIFO holds 3 entries and one read is in flight → no further hcm strobes, no rd_data_valid, wr_ready=1 after release.
